add_cla_pipe: RTL

Parametrised two-stage pipelined carry-lookahead adder/subtractor for the datapath ALU. It generalises the single-bit propagate/generate adder cell to WIDTH bits. Bits are grouped into GROUP-bit lookahead blocks, with a registered group-P/G stage followed by a carry/sum stage. It provides add/subtract mode, ALU flags, a valid pipeline and a stall hold, so it can sit directly in the execute stage.

---
 rtl/add_cla_pipe_pkg.sv | 17 +
 rtl/add_cla_pipe_if.sv | 30 +++
 rtl/add_cla_pipe_cla_group.sv | 39 +++
 rtl/add_cla_pipe.sv | 115 +++++++++++
 4 files changed

// File: rtl/add_cla_pipe_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package add_cla_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_GROUP = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int unsigned group_count(input int unsigned width,
                                              input int unsigned group);
    return width / group;
  endfunction

endpackage

// File: rtl/add_cla_pipe_if.sv
// Operand/result bundle for add_cla_pipe; master drives operands, slave returns results.
interface add_cla_pipe_if
  import add_cla_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, sub, a, b, cin, stall,
    input  out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, sub, a, b, cin, stall,
    output out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/add_cla_pipe_cla_group.sv
// GROUP-bit lookahead block: group propagate/generate plus the carry into every bit.
module cla_group
  import add_cla_pipe_pkg::*;
#(
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] c
);

  logic t;

  // Each carry is a flat sum of products: ci through all lower p, or any lower g through the p above it.
  always_comb begin
    t  = 1'b0;
    c  = '0;
    gp = &p;
    gg = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c[i] = ci;
      for (int unsigned j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int unsigned j = 0; j < i; j++) begin
        t = g[j];
        for (int unsigned k = j + 1; k < i; k++) t = t & p[k];
        c[i] = c[i] | t;
      end
    end
    for (int unsigned j = 0; j < GROUP; j++) begin
      t = g[j];
      for (int unsigned k = j + 1; k < GROUP; k++) t = t & p[k];
      gg = gg | t;
    end
  end

endmodule

// File: rtl/add_cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor: group P/G stage, then carry/sum/flags stage.
module add_cla_pipe
  import add_cla_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input logic          clk,
  input logic          rst,
  add_cla_pipe_if.slave bus
);

  localparam int unsigned NG  = group_count(WIDTH, GROUP);
  localparam int unsigned MSB = WIDTH - 1;

  // stage 1 combinational
  logic [WIDTH-1:0] bx, p0, g0, unused_c0;
  logic [NG-1:0]    gp0, gg0;
  logic             c00;

  always_comb begin
    bx  = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
    c00 = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
    p0  = bus.a ^ bx;
    g0  = bus.a & bx;
  end

  // stage 1 registers
  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0]    gp1, gg1;
  logic             c01, am1, bm1, v1;

  // stage 2 combinational
  logic [NG-1:0]    gc, unused_gp2, unused_gg2;
  logic [WIDTH-1:0] cv, sum_n;
  logic             gp_all, gg_all, cout_n, ovf_n, zero_n;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_pg (
      .p  (p0[k*GROUP +: GROUP]),
      .g  (g0[k*GROUP +: GROUP]),
      .ci (1'b0),
      .gp (gp0[k]),
      .gg (gg0[k]),
      .c  (unused_c0[k*GROUP +: GROUP])
    );
    cla_group #(.GROUP(GROUP)) u_carry (
      .p  (p1[k*GROUP +: GROUP]),
      .g  (g1[k*GROUP +: GROUP]),
      .ci (gc[k]),
      .gp (unused_gp2[k]),
      .gg (unused_gg2[k]),
      .c  (cv[k*GROUP +: GROUP])
    );
  end

  // Second lookahead level: the same block applied across the group P/G vector.
  cla_group #(.GROUP(NG)) u_group_carry (
    .p  (gp1),
    .g  (gg1),
    .ci (c01),
    .gp (gp_all),
    .gg (gg_all),
    .c  (gc)
  );

  always_comb begin
    sum_n  = p1 ^ cv;
    cout_n = gg_all | (gp_all & c01);
    ovf_n  = (am1 == bm1) && (sum_n[MSB] != am1);
    zero_n = ~|sum_n;
  end

  logic [WIDTH-1:0] sum_q;
  logic             vout_q, cout_q, ovf_q, zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1     <= '0;
      g1     <= '0;
      gp1    <= '0;
      gg1    <= '0;
      c01    <= 1'b0;
      am1    <= 1'b0;
      bm1    <= 1'b0;
      v1     <= 1'b0;
      sum_q  <= '0;
      vout_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else if (!bus.stall) begin
      p1     <= p0;
      g1     <= g0;
      gp1    <= gp0;
      gg1    <= gg0;
      c01    <= c00;
      am1    <= bus.a[MSB];
      bm1    <= bx[MSB];
      v1     <= bus.in_valid;
      sum_q  <= sum_n;
      vout_q <= v1;
      cout_q <= cout_n;
      ovf_q  <= ovf_n;
      zero_q <= zero_n;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.out_valid = vout_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
